// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset/exception vectors, fetch FSM states, IF slot payload.
package cpu_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'hBFC0_0380;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Slot handed from IF to the IF/ID register.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            adel;
  } if_slot_t;

  // A fetch address is bad when it is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Buffers the IF slot (pc/inst/adel) while ID is stalled.
module fetch_hold_buf
  import cpu_defs::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  if_slot_t slot_in,
  output if_slot_t slot
);

  // Load on capture, otherwise keep the buffered slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (capture) begin
      slot <= slot_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: SRAM-like instruction port, one request outstanding,
// redirect on exception/eret/branch, hold buffer for ID stalls.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_id_stall,
  input  logic            exc_oc,
  input  logic            eret,
  input  logic [XLEN-1:0] epc,
  input  logic            id_br_taken,
  input  logic [XLEN-1:0] id_br_target,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_adel,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] br_tgt_q, br_tgt_d;
  logic            br_pend_q, br_pend_d;
  logic [XLEN-1:0] seq_tgt, flush_tgt;
  logic            flush, misaligned;
  logic            capture, handoff, slot_valid;
  if_slot_t        slot_in, hold_slot;

  assign flush      = exc_oc | eret;
  assign flush_tgt  = exc_oc ? EXC_VEC : epc;
  assign misaligned = is_misaligned(pc_q[1:0]);

  // Address after the current slot: a branch resolving now wins over a latched one.
  assign seq_tgt = id_br_taken ? id_br_target
                 : (br_pend_q ? br_tgt_q : XLEN'(pc_q + PC_STEP));

  // State, fetch PC and latched branch target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
    end
  end

  // Next state, next PC, slot valid and hold-buffer capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    capture    = 1'b0;
    handoff    = 1'b0;
    slot_valid = 1'b0;

    case (state_q)
      REQ: begin
        if (flush) begin
          pc_d    = flush_tgt;
          // A request accepted this cycle still owes a response.
          state_d = (!misaligned && inst_addr_ok) ? DROP : REQ;
        end else if (misaligned) begin
          slot_valid = 1'b1;
          if (if_id_stall) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            handoff = 1'b1;
          end
        end else if (inst_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          pc_d    = flush_tgt;
          state_d = inst_data_ok ? REQ : DROP;
        end else if (inst_data_ok) begin
          slot_valid = 1'b1;
          if (if_id_stall) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            handoff = 1'b1;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d    = flush_tgt;
          state_d = REQ;
        end else begin
          slot_valid = 1'b1;
          handoff    = ~if_id_stall;
        end
      end
      DROP: begin
        if (flush) begin
          pc_d = flush_tgt;
        end
        if (inst_data_ok) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (flush) begin
      br_pend_d = 1'b0;
    end else if (handoff) begin
      pc_d      = seq_tgt;
      state_d   = REQ;
      br_pend_d = 1'b0;
    end else if (id_br_taken) begin
      br_pend_d = 1'b1;
      br_tgt_d  = id_br_target;
    end
  end

  // Slot presented to the hold buffer when ID cannot take it.
  always_comb begin
    slot_in      = '0;
    slot_in.pc   = pc_q;
    slot_in.inst = misaligned ? '0 : inst_rdata;
    slot_in.adel = misaligned;
  end

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .slot_in (slot_in),
    .slot    (hold_slot)
  );

  // Port outputs; everything is forced quiet while reset is held.
  assign inst_req  = ~rst & (state_q == REQ) & ~misaligned;
  assign inst_addr = rst ? RESET_PC : pc_q;
  assign if_valid  = ~rst & slot_valid;
  assign if_pc     = rst ? '0 : ((state_q == HOLD) ? hold_slot.pc : pc_q);
  assign if_inst   = rst ? '0
                   : ((state_q == HOLD) ? hold_slot.inst
                   : ((state_q == WAIT) ? inst_rdata : '0));
  assign if_adel   = ~rst & slot_valid
                   & ((state_q == HOLD) ? hold_slot.adel : misaligned);

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q;

  // Handoff and memory/ID stall counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (handoff) begin
        fetch_cnt_q <= XLEN'(fetch_cnt_q + 32'd1);
      end
      if ((state_q == WAIT) || (state_q == HOLD)) begin
        stall_cnt_q <= XLEN'(stall_cnt_q + 32'd1);
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
